// File: rtl/pcie_descrambler.sv
// Purpose: PCIe Gen1/Gen2 receive descrambler for 1/2/4 symbols per cycle (LFSR x^16+x^5+x^4+x^3+1).
// Latency: 1 cycle, every output registered.
// Backpressure: none; accepts one word per cycle whenever valid_i is high.
//
// Ports:
//   clk_i, rst_ni          clock (rising edge), asynchronous active-low reset
//   valid_i/datak_i/data_len_i/indata_i  input word (byte 0 = [7:0] first in time)
//   scram_dis_i            pass D bytes unmodified while still tracking the LFSR
//   resync_i               forces the lock FSM back to UNLOCKED
//   valid_o/datak_o/data_len_o/descrambled_data_o  output word (unused lanes are 0)
//   locked_o               lock FSM is in LOCKED
//   err_o                  a valid word with illegal length (11) was dropped
module pcie_descrambler (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    input  logic [3:0]  datak_i,
    input  logic [1:0]  data_len_i,
    input  logic [31:0] indata_i,
    input  logic        scram_dis_i,
    input  logic        resync_i,
    output logic        valid_o,
    output logic [3:0]  datak_o,
    output logic [1:0]  data_len_o,
    output logic [31:0] descrambled_data_o,
    output logic        locked_o,
    output logic        err_o
);

    localparam logic [15:0] LFSR_SEED = 16'hFFFF;
    localparam logic [7:0]  SYM_COM   = 8'hBC;
    localparam logic [7:0]  SYM_SKP   = 8'h1C;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] lfsr;
    logic [15:0] lfsr_nxt;
    logic [31:0] data_nxt;
    logic [3:0]  datak_nxt;
    logic [3:0]  lane_en;
    logic        len_bad;
    logic        com_seen;

    // Eight serial LFSR steps: returns {key byte (first step in bit 0), next LFSR}.
    function automatic logic [23:0] step8(input logic [15:0] s);
        logic [15:0] r;
        logic [7:0]  k;
        r = s;
        k = 8'h00;
        for (int b = 0; b < 8; b++) begin
            k[b] = r[15];
            r    = {r[14:0], 1'b0} ^ (r[15] ? 16'h0039 : 16'h0000);
        end
        return {k, r};
    endfunction

    always_comb begin
        lane_en = 4'b0000;
        case (data_len_i)
            2'b00:   lane_en = 4'b0001;
            2'b01:   lane_en = 4'b0011;
            2'b10:   lane_en = 4'b1111;
            default: lane_en = 4'b0000;
        endcase
    end

    assign len_bad = (data_len_i == 2'b11);

    // Lanes are chained: each lane starts from the LFSR left by the previous
    // lane, and a COM locks the remaining lanes of the same word.
    always_comb begin
        logic        lk;
        logic [15:0] l;
        logic [23:0] st;
        logic [7:0]  b;
        lk        = (state == LOCKED);
        l         = lfsr;
        st        = 24'h0;
        b         = 8'h00;
        data_nxt  = 32'h0;
        datak_nxt = 4'h0;
        com_seen  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) begin
                b            = indata_i[8*i +: 8];
                datak_nxt[i] = datak_i[i];
                st           = step8(l);
                if (datak_i[i]) begin
                    data_nxt[8*i +: 8] = b;
                    if (b == SYM_COM) begin
                        l        = LFSR_SEED;
                        lk       = 1'b1;
                        com_seen = 1'b1;
                    end else if (b != SYM_SKP) begin
                        l = st[15:0];
                    end
                end else begin
                    data_nxt[8*i +: 8] = (lk && !scram_dis_i) ? (b ^ st[23:16]) : b;
                    l = st[15:0];
                end
            end
        end
        lfsr_nxt = l;
    end

    // resync wins over a COM in the same word; the LFSR reseed still happens.
    always_comb begin
        state_nxt = state;
        if (valid_i && !len_bad && com_seen) begin
            state_nxt = LOCKED;
        end
        if (resync_i) begin
            state_nxt = UNLOCKED;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state              <= UNLOCKED;
            lfsr               <= LFSR_SEED;
            valid_o            <= 1'b0;
            datak_o            <= 4'h0;
            data_len_o         <= 2'b00;
            descrambled_data_o <= 32'h0;
            locked_o           <= 1'b0;
            err_o              <= 1'b0;
        end else begin
            state    <= state_nxt;
            locked_o <= (state_nxt == LOCKED);
            valid_o  <= valid_i && !len_bad;
            err_o    <= valid_i && len_bad;
            if (valid_i && !len_bad) begin
                lfsr               <= lfsr_nxt;
                datak_o            <= datak_nxt;
                data_len_o         <= data_len_i;
                descrambled_data_o <= data_nxt;
            end
        end
    end

endmodule

// File: tb/tb_pcie_descrambler.sv
// Purpose: directed self-checking bench for pcie_descrambler with an expected-result queue.
// Latency: expectations are pushed when a word is driven and popped one cycle later.
// Backpressure: none; the DUT is driven at full rate with bubbles where needed.
module tb_pcie_descrambler;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic [3:0]  datak_i;
    logic [1:0]  data_len_i;
    logic [31:0] indata_i;
    logic        scram_dis_i;
    logic        resync_i;
    logic        valid_o;
    logic [3:0]  datak_o;
    logic [1:0]  data_len_o;
    logic [31:0] descrambled_data_o;
    logic        locked_o;
    logic        err_o;

    typedef struct {
        logic        chk_data;
        logic        vld;
        logic [3:0]  k;
        logic [1:0]  len;
        logic [31:0] dat;
        logic        locked;
        logic        err;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    pcie_descrambler dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .valid_i            (valid_i),
        .datak_i            (datak_i),
        .data_len_i         (data_len_i),
        .indata_i           (indata_i),
        .scram_dis_i        (scram_dis_i),
        .resync_i           (resync_i),
        .valid_o            (valid_o),
        .datak_o            (datak_o),
        .data_len_o         (data_len_o),
        .descrambled_data_o (descrambled_data_o),
        .locked_o           (locked_o),
        .err_o              (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive one word at the falling edge, push its expectation, then
    // pop and compare after the next rising edge.
    task automatic cycle(input string tag, input logic vld, input logic [3:0] k,
                         input logic [1:0] len, input logic [31:0] dat,
                         input logic dis, input logic rsy,
                         input logic chk_data, input logic e_vld, input logic [3:0] e_k,
                         input logic [31:0] e_dat, input logic e_lock, input logic e_err);
        exp_t e;
        @(negedge clk);
        valid_i     = vld;
        datak_i     = k;
        data_len_i  = len;
        indata_i    = dat;
        scram_dis_i = dis;
        resync_i    = rsy;
        e.chk_data  = chk_data;
        e.vld       = e_vld;
        e.k         = e_k;
        e.len       = len;
        e.dat       = e_dat;
        e.locked    = e_lock;
        e.err       = e_err;
        e.tag       = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        valid_i  = 1'b0;
        resync_i = 1'b0;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({e.tag, "_valid"}, {31'd0, valid_o}, {31'd0, e.vld});
            check({e.tag, "_err"}, {31'd0, err_o}, {31'd0, e.err});
            check({e.tag, "_locked"}, {31'd0, locked_o}, {31'd0, e.locked});
            if (e.chk_data) begin
                check({e.tag, "_data"}, descrambled_data_o, e.dat);
                check({e.tag, "_datak"}, {28'd0, datak_o}, {28'd0, e.k});
                check({e.tag, "_len"}, {30'd0, data_len_o}, {30'd0, e.len});
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
        check({tag, "_datak"}, {28'd0, datak_o}, 32'd0);
        check({tag, "_len"}, {30'd0, data_len_o}, 32'd0);
        check({tag, "_data"}, descrambled_data_o, 32'd0);
        check({tag, "_locked"}, {31'd0, locked_o}, 32'd0);
        check({tag, "_err"}, {31'd0, err_o}, 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        valid_i     = 1'b0;
        datak_i     = 4'h0;
        data_len_i  = 2'b00;
        indata_i    = 32'h0;
        scram_dis_i = 1'b0;
        resync_i    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Lock on COM; upper lanes of a 1-byte word must read back 0.
        cycle("com_lock", 1, 4'b0001, 2'b00, 32'hAABBCCBC, 0, 0,
              1, 1, 4'b0001, 32'h000000BC, 1, 0);
        // Keys after seed: FF 17 C0 14 B2 E7 02 82.
        cycle("desc_w1", 1, 4'b0000, 2'b10, 32'h14C017FF, 0, 0,
              1, 1, 4'b0000, 32'h00000000, 1, 0);
        cycle("desc_w2", 1, 4'b0000, 2'b10, 32'h8202E7B2, 0, 0,
              1, 1, 4'b0000, 32'h00000000, 1, 0);

        // SKP must not advance the LFSR.
        cycle("skp_com", 1, 4'b0001, 2'b00, 32'h000000BC, 0, 0,
              1, 1, 4'b0001, 32'h000000BC, 1, 0);
        cycle("skp_sym", 1, 4'b0001, 2'b00, 32'h0000001C, 0, 0,
              1, 1, 4'b0001, 32'h0000001C, 1, 0);
        cycle("skp_d", 1, 4'b0000, 2'b01, 32'h000017FF, 0, 0,
              1, 1, 4'b0000, 32'h00000000, 1, 0);

        // Unlock, then COM in lane 1: lane 0 passes, lanes 2/3 use keys FF, 17.
        cycle("resync1", 0, 4'b0000, 2'b00, 32'h0, 0, 1,
              0, 0, 4'b0000, 32'h0, 0, 0);
        cycle("intra_com", 1, 4'b0010, 2'b10, 32'h17FFBC55, 0, 0,
              1, 1, 4'b0010, 32'h0000BC55, 1, 0);

        // Illegal length and bubbles leave the LFSR untouched.
        cycle("ill_com", 1, 4'b0001, 2'b00, 32'h000000BC, 0, 0,
              1, 1, 4'b0001, 32'h000000BC, 1, 0);
        cycle("ill_len", 1, 4'b0000, 2'b11, 32'hDEADBEEF, 0, 0,
              0, 0, 4'b0000, 32'h0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            cycle("bubble", 0, 4'b0000, 2'b00, 32'h12345678, 0, 0,
                  0, 0, 4'b0000, 32'h0, 1, 0);
        end
        cycle("ill_after", 1, 4'b0000, 2'b00, 32'h000000FF, 0, 0,
              1, 1, 4'b0000, 32'h00000000, 1, 0);

        // Scrambling disabled still consumes key FF; next D uses key 17.
        cycle("dis_com", 1, 4'b0001, 2'b00, 32'h000000BC, 0, 0,
              1, 1, 4'b0001, 32'h000000BC, 1, 0);
        cycle("dis_d", 1, 4'b0000, 2'b00, 32'h000000FF, 1, 0,
              1, 1, 4'b0000, 32'h000000FF, 1, 0);
        cycle("dis_after", 1, 4'b0000, 2'b00, 32'h00000017, 0, 0,
              1, 1, 4'b0000, 32'h00000000, 1, 0);

        // Resync: lock drops and D passes through.
        cycle("resync2", 0, 4'b0000, 2'b00, 32'h0, 0, 1,
              0, 0, 4'b0000, 32'h0, 0, 0);
        cycle("unlocked_d", 1, 4'b0000, 2'b00, 32'h00000012, 0, 0,
              1, 1, 4'b0000, 32'h00000012, 0, 0);

        // Reset mid-traffic: outputs clear immediately, lock is lost.
        cycle("pre_rst_com", 1, 4'b0001, 2'b00, 32'h000000BC, 0, 0,
              1, 1, 4'b0001, 32'h000000BC, 1, 0);
        @(negedge clk);
        valid_i    = 1'b1;
        datak_i    = 4'b0000;
        data_len_i = 2'b10;
        indata_i   = 32'h14C017FF;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        exp_q.delete();
        valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle("post_rst_d", 1, 4'b0000, 2'b00, 32'h0000005A, 0, 0,
              1, 1, 4'b0000, 32'h0000005A, 0, 0);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
